// File: rtl/mem_timer_pkg.sv
// Shared types and constants for the memory wait-state timer.
// DEF_CYCLES = 12 gives the standard 13-cycle ROM select window.
package mem_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_CNT_W  = 4;
  localparam int DEF_CYCLES = 12;

endpackage

// File: rtl/wait_timer_ch.sv
// One wait-state channel: holds its select for target+1 cycles after a start,
// then drops it and pulses done. Abort cancels the window silently.
//
//   state | meaning
//   IDLE  | select low, waiting for a start request
//   RUN   | select high, count climbing toward the latched target
module wait_timer_ch
  import mem_timer_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter bit RETRIG_EN = 1'b0
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             start_timer,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_cycles,
  output logic             ROMsel,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             done_d;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      target_q <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      done     <= done_d;
    end
  end

  // Priority: abort, then retrigger reload, then expiry, then increment.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_timer) begin
            state_d  = RUN;
            count_d  = '0;
            target_d = cfg_cycles;
          end
        end
        RUN: begin
          if (RETRIG_EN && start_timer) begin
            count_d  = '0;
            target_d = cfg_cycles;
          end else if (count_q == target_q) begin
            state_d = IDLE;
            count_d = '0;
            done_d  = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The select is the state flop itself, so it is glitch-free toward the memory.
  assign ROMsel = (state_q == RUN);

endmodule

// File: rtl/mem_wait_timer.sv
// Multi-channel wait-state timer: NUM_CH independent select windows between
// the control unit and the memory selects, plus a combined busy flag.
module mem_wait_timer
  import mem_timer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = DEF_CNT_W,
  parameter bit RETRIG_EN = 1'b0
) (
  input  logic                    Clk,
  input  logic                    Resetn,
  input  logic [NUM_CH-1:0]       start_timer,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH*CNT_W-1:0] cfg_cycles,
  output logic [NUM_CH-1:0]       ROMsel,
  output logic [NUM_CH-1:0]       done,
  output logic                    busy_any
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wait_timer_ch #(
      .CNT_W     (CNT_W),
      .RETRIG_EN (RETRIG_EN)
    ) u_ch (
      .Clk         (Clk),
      .Resetn      (Resetn),
      .start_timer (start_timer[i]),
      .abort       (abort[i]),
      .cfg_cycles  (cfg_cycles[i*CNT_W +: CNT_W]),
      .ROMsel      (ROMsel[i]),
      .done        (done[i])
    );
  end

  assign busy_any = |ROMsel;

endmodule

// File: tb/tb_mem_wait_timer.sv
// Self-checking bench for mem_wait_timer: one instance per retrigger mode,
// directed scenarios plus a randomized run against a remaining-cycles model.
module tb_mem_wait_timer;
  import mem_timer_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;

  logic                    Clk = 1'b0;
  logic                    Resetn;
  logic [NUM_CH-1:0]       start_timer;
  logic [NUM_CH-1:0]       abort;
  logic [NUM_CH*CNT_W-1:0] cfg_cycles;
  logic [NUM_CH-1:0]       rs0, dn0, rs1, dn1;
  logic                    busy0, busy1;

  int tests_run = 0;
  int fails     = 0;

  // Model: a channel is active with rem select cycles still to go.
  bit m_act  [2][NUM_CH];
  int m_rem  [2][NUM_CH];
  bit m_done [2][NUM_CH];

  always #5 Clk = ~Clk;

  mem_wait_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RETRIG_EN(1'b0)) dut0 (
    .Clk(Clk), .Resetn(Resetn), .start_timer(start_timer), .abort(abort),
    .cfg_cycles(cfg_cycles), .ROMsel(rs0), .done(dn0), .busy_any(busy0));

  mem_wait_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RETRIG_EN(1'b1)) dut1 (
    .Clk(Clk), .Resetn(Resetn), .start_timer(start_timer), .abort(abort),
    .cfg_cycles(cfg_cycles), .ROMsel(rs1), .done(dn1), .busy_any(busy1));

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NUM_CH; c++) begin
        m_act[d][c] = 1'b0; m_rem[d][c] = 0; m_done[d][c] = 1'b0;
      end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NUM_CH; c++) begin
        logic st;
        logic ab;
        int   cf;
        st = start_timer[c];
        ab = abort[c];
        cf = int'(cfg_cycles[c*CNT_W +: CNT_W]);
        m_done[d][c] = 1'b0;
        if (ab) begin
          m_act[d][c] = 1'b0; m_rem[d][c] = 0;
        end else if (!m_act[d][c]) begin
          if (st) begin m_act[d][c] = 1'b1; m_rem[d][c] = cf + 1; end
        end else if (d == 1 && st) begin
          m_rem[d][c] = cf + 1;
        end else begin
          m_rem[d][c] = m_rem[d][c] - 1;
          if (m_rem[d][c] == 0) begin m_act[d][c] = 1'b0; m_done[d][c] = 1'b1; end
        end
      end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic set_cfg(input int ch, input logic [CNT_W-1:0] v);
    cfg_cycles[ch*CNT_W +: CNT_W] = v;
  endtask

  task automatic idle_inputs();
    start_timer = '0; abort = '0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; idle_inputs(); cfg_cycles = '0;
    model_reset();
    #22;
    tests_run++; if (rs0 !== 4'b0)  begin fails++; $display("FAIL reset_romsel0 got=%b exp=0000", rs0); end
    tests_run++; if (dn0 !== 4'b0)  begin fails++; $display("FAIL reset_done0 got=%b exp=0000", dn0); end
    tests_run++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
    tests_run++; if (rs1 !== 4'b0)  begin fails++; $display("FAIL reset_romsel1 got=%b exp=0000", rs1); end
    Resetn = 1'b1;
  endtask

  task automatic test_single_window();
    int hi = 0, fall = -1, done_at = -1, dcnt = 0;
    bit others = 0;
    set_cfg(0, 4'(DEF_CYCLES));
    start_timer[0] = 1'b1; tick(); start_timer[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rs0[0]) hi++;
      else if (fall < 0) fall = i;
      if (dn0[0]) begin dcnt++; if (done_at < 0) done_at = i; end
      if ((rs0[3:1] | dn0[3:1]) != 3'b0) others = 1;
      tick();
    end
    tests_run++; if (hi != 13)     begin fails++; $display("FAIL single_len got=%0d exp=13", hi); end
    tests_run++; if (fall != 13)   begin fails++; $display("FAIL single_fall got=%0d exp=13", fall); end
    tests_run++; if (done_at != 13) begin fails++; $display("FAIL single_done_pos got=%0d exp=13", done_at); end
    tests_run++; if (dcnt != 1)    begin fails++; $display("FAIL single_done_cnt got=%0d exp=1", dcnt); end
    tests_run++; if (others)       begin fails++; $display("FAIL single_other_ch got=1 exp=0"); end
  endtask

  task automatic test_cfg_zero();
    set_cfg(2, 4'd0);
    start_timer[2] = 1'b1; tick(); start_timer[2] = 1'b0;
    tests_run++; if (rs0[2] !== 1'b1) begin fails++; $display("FAIL zero_sel_hi got=%b exp=1", rs0[2]); end
    tests_run++; if (busy0 !== 1'b1)  begin fails++; $display("FAIL zero_busy_hi got=%b exp=1", busy0); end
    tests_run++; if (dn0[2] !== 1'b0) begin fails++; $display("FAIL zero_done_early got=%b exp=0", dn0[2]); end
    tick();
    tests_run++; if (rs0[2] !== 1'b0) begin fails++; $display("FAIL zero_sel_lo got=%b exp=0", rs0[2]); end
    tests_run++; if (dn0[2] !== 1'b1) begin fails++; $display("FAIL zero_done got=%b exp=1", dn0[2]); end
    tests_run++; if (busy0 !== 1'b0)  begin fails++; $display("FAIL zero_busy_lo got=%b exp=0", busy0); end
    tick();
    tests_run++; if (dn0[2] !== 1'b0) begin fails++; $display("FAIL zero_done_clr got=%b exp=0", dn0[2]); end
  endtask

  task automatic test_held_start();
    int dcnt0 = 0;
    bit bad1 = 0;
    set_cfg(1, 4'd3);
    start_timer[1] = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      logic esel, edone;
      esel  = (k % 5) < 4;
      edone = (k % 5) == 4;
      tests_run++; if (rs0[1] !== esel)  begin fails++; $display("FAIL held_sel k=%0d got=%b exp=%b", k, rs0[1], esel); end
      tests_run++; if (dn0[1] !== edone) begin fails++; $display("FAIL held_done k=%0d got=%b exp=%b", k, dn0[1], edone); end
      if (dn0[1]) dcnt0++;
      if (rs1[1] !== 1'b1 || dn1[1] !== 1'b0) bad1 = 1;
      if (k < 19) tick();
    end
    tests_run++; if (dcnt0 != 4) begin fails++; $display("FAIL held_done_cnt got=%0d exp=4", dcnt0); end
    tests_run++; if (bad1) begin fails++; $display("FAIL held_retrig_stays_hi got=gap exp=solid"); end
    start_timer[1] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_retrigger();
    int hi0 = 0, hi1 = 0, d0 = 0, d1 = 0, fall1 = -1;
    set_cfg(3, 4'(DEF_CYCLES));
    for (int i = 0; i < 30; i++) begin
      start_timer[3] = (i == 0 || i == 5);
      tick();
      if (rs0[3]) hi0++;
      if (rs1[3]) hi1++;
      else if (fall1 < 0) fall1 = i;
      if (dn0[3]) d0++;
      if (dn1[3]) d1++;
    end
    start_timer[3] = 1'b0;
    tests_run++; if (hi1 != 18)  begin fails++; $display("FAIL retrig_len got=%0d exp=18", hi1); end
    tests_run++; if (fall1 != 18) begin fails++; $display("FAIL retrig_contig got=%0d exp=18", fall1); end
    tests_run++; if (d1 != 1)    begin fails++; $display("FAIL retrig_done_cnt got=%0d exp=1", d1); end
    tests_run++; if (hi0 != 13)  begin fails++; $display("FAIL noretrig_len got=%0d exp=13", hi0); end
    tests_run++; if (d0 != 1)    begin fails++; $display("FAIL noretrig_done_cnt got=%0d exp=1", d0); end
  endtask

  task automatic test_abort();
    int dsum = 0, hsum = 0;
    set_cfg(0, 4'd12);
    start_timer[0] = 1'b1; tick(); start_timer[0] = 1'b0;
    repeat (3) tick();
    tests_run++; if (rs0[0] !== 1'b1) begin fails++; $display("FAIL abort_pre_sel got=%b exp=1", rs0[0]); end
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
    tests_run++; if (rs0[0] !== 1'b0) begin fails++; $display("FAIL abort_sel got=%b exp=0", rs0[0]); end
    tests_run++; if (rs1[0] !== 1'b0) begin fails++; $display("FAIL abort_sel1 got=%b exp=0", rs1[0]); end
    for (int i = 0; i < 15; i++) begin
      if (dn0[0] || dn1[0]) dsum++;
      if (rs0[0] || rs1[0]) hsum++;
      tick();
    end
    tests_run++; if (dsum != 0) begin fails++; $display("FAIL abort_no_done got=%0d exp=0", dsum); end
    tests_run++; if (hsum != 0) begin fails++; $display("FAIL abort_stays_lo got=%0d exp=0", hsum); end
    start_timer[0] = 1'b1; abort[0] = 1'b1; tick();
    tests_run++; if (rs0[0] !== 1'b0) begin fails++; $display("FAIL abort_start_idle got=%b exp=0", rs0[0]); end
    start_timer[0] = 1'b0; abort[0] = 1'b0; tick();
    tests_run++; if (rs0[0] !== 1'b0 || dn0[0] !== 1'b0) begin
      fails++; $display("FAIL abort_start_after got=%b%b exp=00", rs0[0], dn0[0]);
    end
  endtask

  task automatic test_reset_and_cfg();
    int hi = 0, dc = 0;
    set_cfg(0, 4'd12); set_cfg(2, 4'd7);
    start_timer = 4'b0101; tick(); idle_inputs();
    repeat (4) tick();
    #2 Resetn = 1'b0;
    #1;
    tests_run++; if (rs0 !== 4'b0 || busy0 !== 1'b0) begin
      fails++; $display("FAIL async_reset0 got=%b/%b exp=0000/0", rs0, busy0);
    end
    tests_run++; if (rs1 !== 4'b0 || busy1 !== 1'b0) begin
      fails++; $display("FAIL async_reset1 got=%b/%b exp=0000/0", rs1, busy1);
    end
    #3 Resetn = 1'b1;
    model_reset();
    tick();
    tests_run++; if (dn0 !== 4'b0) begin fails++; $display("FAIL async_reset_no_done got=%b exp=0000", dn0); end
    start_timer[0] = 1'b1; tick(); start_timer[0] = 1'b0;
    set_cfg(0, 4'd2);
    for (int i = 0; i < 20; i++) begin
      if (rs0[0]) hi++;
      if (dn0[0]) dc++;
      tick();
    end
    tests_run++; if (hi != 13) begin fails++; $display("FAIL cfg_change_len got=%0d exp=13", hi); end
    tests_run++; if (dc != 1)  begin fails++; $display("FAIL cfg_change_done got=%0d exp=1", dc); end
  endtask

  task automatic test_concurrent();
    int hi [NUM_CH];
    int cfgs [NUM_CH];
    cfgs[0] = 5; cfgs[1] = 0; cfgs[2] = 9; cfgs[3] = 15;
    for (int c = 0; c < NUM_CH; c++) begin
      hi[c] = 0; set_cfg(c, 4'(cfgs[c]));
    end
    start_timer = 4'b1111; tick(); start_timer = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < NUM_CH; c++) if (rs0[c]) hi[c]++;
      tick();
    end
    for (int c = 0; c < NUM_CH; c++) begin
      tests_run++;
      if (hi[c] != cfgs[c] + 1) begin
        fails++; $display("FAIL concurrent_len ch=%0d got=%0d exp=%0d", c, hi[c], cfgs[c] + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] es0, ed0, es1, ed1;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        start_timer[c] = ($urandom_range(0, 99) < 30);
        abort[c]       = ($urandom_range(0, 99) < 6);
        if ($urandom_range(0, 99) < 40) set_cfg(c, 4'($urandom_range(0, 15)));
      end
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        es0[c] = m_act[0][c]; ed0[c] = m_done[0][c];
        es1[c] = m_act[1][c]; ed1[c] = m_done[1][c];
      end
      tests_run++; if (rs0 !== es0) begin fails++; $display("FAIL rand_sel0 cyc=%0d got=%b exp=%b", i, rs0, es0); end
      tests_run++; if (dn0 !== ed0) begin fails++; $display("FAIL rand_done0 cyc=%0d got=%b exp=%b", i, dn0, ed0); end
      tests_run++; if (busy0 !== (|es0)) begin fails++; $display("FAIL rand_busy0 cyc=%0d got=%b exp=%b", i, busy0, |es0); end
      tests_run++; if (rs1 !== es1) begin fails++; $display("FAIL rand_sel1 cyc=%0d got=%b exp=%b", i, rs1, es1); end
      tests_run++; if (dn1 !== ed1) begin fails++; $display("FAIL rand_done1 cyc=%0d got=%b exp=%b", i, dn1, ed1); end
      tests_run++; if (busy1 !== (|es1)) begin fails++; $display("FAIL rand_busy1 cyc=%0d got=%b exp=%b", i, busy1, |es1); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_cfg_zero();
    test_held_start();
    test_retrigger();
    test_abort();
    test_reset_and_cfg();
    test_concurrent();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
